// File: rtl/lcd_pkg.sv
// lcd_pkg: definitions shared by the LCD display blocks.
//   state_t        - marquee controller state (IDLE / RUN / DONE)
//   FILL_SPACE     - ASCII space, the default fill character
//   DIR_RIGHT/LEFT - values of the marquee `dir` input
//   MODE_ROTATE/SHIFTOUT - values of the marquee `mode` input
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] FILL_SPACE    = 8'h20;

    localparam logic       DIR_RIGHT     = 1'b0;
    localparam logic       DIR_LEFT      = 1'b1;

    localparam logic       MODE_ROTATE   = 1'b0;
    localparam logic       MODE_SHIFTOUT = 1'b1;

endpackage

// File: rtl/tick_div.sv
// tick_div: prescaler that produces one tick every DIV enabled cycles.
//   clk  - clock (rising edge)
//   rst  - asynchronous active-high reset, count -> 0
//   clr  - synchronous clear, count -> 0; suppresses tick in that cycle
//   en   - count only while high
//   tick - high in the cycle whose rising edge ends an enabled count of DIV
module tick_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          at_end;

    assign at_end = (cnt == CW'(DIV - 1));
    // A clear request always wins, so callers can cancel a due tick.
    assign tick   = en && !clr && at_end;

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values and the block order never changes the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_end ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lcd_marquee.sv
// lcd_marquee: scrolls a CHARS-character text register left or right.
//   clk, rst          - clock / asynchronous active-high reset
//   load, load_data   - replace the text (MSB character = leftmost), pos -> 0
//   start, stop       - begin / halt scrolling (stop wins)
//   dir               - 0 right, 1 left; sampled at each shift
//   mode              - 0 rotate forever, 1 shift FILL in and end after CHARS steps
//   out               - current text (registered)
//   pos               - steps since last load, modulo CHARS
//   busy              - high while running
//   step, wrap        - one-cycle pulses on each shift / on pos returning to 0
module lcd_marquee
    import lcd_pkg::*;
#(
    parameter int                CHARS  = 16,
    parameter int                CHAR_W = 8,
    parameter int                DIV    = 1,
    parameter logic [CHAR_W-1:0] FILL   = FILL_SPACE
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     load,
    input  logic [CHARS*CHAR_W-1:0]                  load_data,
    input  logic                                     start,
    input  logic                                     stop,
    input  logic                                     dir,
    input  logic                                     mode,
    output logic [CHARS*CHAR_W-1:0]                  out,
    output logic [((CHARS > 1) ? $clog2(CHARS) : 1)-1:0] pos,
    output logic                                     busy,
    output logic                                     step,
    output logic                                     wrap
);

    localparam int W  = CHARS * CHAR_W;
    localparam int PW = (CHARS > 1) ? $clog2(CHARS) : 1;

    state_t          state;
    logic            idle_start;
    logic            div_clr;
    logic            div_en;
    logic            shift;
    logic            last;
    logic [W-1:0]    fill_w;
    logic [W-1:0]    next_out;

    assign idle_start = (state == ST_IDLE) && start && !stop;
    // Clearing on stop and load also cancels a shift due in the same cycle.
    assign div_clr    = load || stop || idle_start;
    assign div_en     = (state == ST_RUN);
    assign last       = (pos == PW'(CHARS - 1));
    assign fill_w     = W'(FILL);
    assign busy       = (state == ST_RUN);

    tick_div #(
        .DIV (DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .en   (div_en),
        .tick (shift)
    );

    // Shifts are written with whole-vector shifts so CHARS = 1 needs no
    // special case: the wrapped character is either the old one or FILL.
    // NOTE: next_out is given its value on every path so no latch is inferred.
    always_comb begin
        next_out = out;
        if (dir == DIR_LEFT) begin
            next_out = (out << CHAR_W)
                     | ((mode == MODE_SHIFTOUT) ? fill_w : (out >> (W - CHAR_W)));
        end else begin
            next_out = (out >> CHAR_W)
                     | (((mode == MODE_SHIFTOUT) ? fill_w : out) << (W - CHAR_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            out   <= {CHARS{FILL}};
            pos   <= '0;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;

            if (load) begin
                out <= load_data;
                pos <= '0;
            end else if (shift) begin
                out  <= next_out;
                pos  <= last ? '0 : pos + PW'(1);
                step <= 1'b1;
                wrap <= last;
            end

            case (state)
                ST_IDLE: if (idle_start) state <= ST_RUN;
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (shift && last && (mode == MODE_SHIFTOUT)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: if (load) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
